// File: rtl/uart_frame_mux_if.sv
// Word-level handshake between the frame multiplexer and the UART word transmitter.
interface uart_frame_mux_if #(
    parameter int unsigned WORD_W = 16
) ();
    logic [WORD_W-1:0] data_out;
    logic              tx_start;
    logic              tx_done;

    modport master (output data_out, output tx_start, input tx_done);
    modport slave  (input data_out, input tx_start, output tx_done);
endinterface

// File: rtl/uart_frame_mux.sv
// Snapshots N_FIELDS game-state words and sends SYNC, fields and an XOR checksum
// as one frame per period, with a per-word tx_done timeout.
module uart_frame_mux #(
    parameter int unsigned       WORD_W     = 16,
    parameter int unsigned       N_FIELDS   = 6,
    parameter logic [WORD_W-1:0] SYNC_WORD  = WORD_W'(16'hA55A),
    parameter int unsigned       FRAME_GAP  = 65000,
    parameter int unsigned       TX_TIMEOUT = 4096
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [N_FIELDS*WORD_W-1:0] fields_in,
    uart_frame_mux_if.master           tx_if,
    output logic                       busy,
    output logic                       frame_sent,
    output logic                       tx_err,
    output logic [7:0]                 frame_cnt
);
    localparam int unsigned IDX_W = $clog2(N_FIELDS + 2);
    localparam int unsigned TMO_W = $clog2(TX_TIMEOUT);
    localparam int unsigned GAP_W = $clog2(FRAME_GAP + 1);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_FIELDS + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TX_TIMEOUT - 2);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(FRAME_GAP - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SNAP = 3'd1;
    localparam logic [2:0] S_LOAD = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;

    logic [2:0]        r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [TMO_W-1:0]  r_tmo;
    logic [GAP_W-1:0]  r_gap;
    logic [WORD_W-1:0] r_csum;
    logic [WORD_W-1:0] r_data;
    logic              r_start;
    logic              r_busy;
    logic              r_sent;
    logic              r_err;
    logic [7:0]        r_cnt;
    logic [WORD_W-1:0] r_shadow [N_FIELDS];

    logic [2:0]        w_state_nxt;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic [TMO_W-1:0]  w_tmo_nxt;
    logic [GAP_W-1:0]  w_gap_nxt;
    logic [WORD_W-1:0] w_csum_nxt;
    logic [WORD_W-1:0] w_data_nxt;
    logic              w_start_nxt;
    logic              w_busy_nxt;
    logic              w_sent_nxt;
    logic              w_err_nxt;
    logic [7:0]        w_cnt_nxt;
    logic              w_snap;
    logic              w_done;
    logic [WORD_W-1:0] w_field;

    // A tx_done coinciding with our own tx_start cannot answer it, so it is dropped.
    assign w_done = tx_if.tx_done & ~r_start;

    always_comb begin
        w_field = '0;
        for (int k = 0; k < N_FIELDS; k++) begin
            if (r_idx == IDX_W'(k + 1)) begin
                w_field = r_shadow[k];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_tmo_nxt   = r_tmo;
        w_gap_nxt   = r_gap;
        w_csum_nxt  = r_csum;
        w_data_nxt  = r_data;
        w_start_nxt = 1'b0;
        w_sent_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_cnt_nxt   = r_cnt;
        w_snap      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_state_nxt = S_SNAP;
                end
            end
            S_SNAP: begin
                w_snap      = 1'b1;
                w_csum_nxt  = '0;
                w_idx_nxt   = '0;
                w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (r_idx == '0) begin
                    w_data_nxt = SYNC_WORD;
                end else if (r_idx == IDX_LAST) begin
                    w_data_nxt = r_csum;
                end else begin
                    w_data_nxt = w_field;
                end
                w_start_nxt = 1'b1;
                w_tmo_nxt   = '0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (w_done) begin
                    if ((r_idx != '0) && (r_idx != IDX_LAST)) begin
                        w_csum_nxt = r_csum ^ r_data;
                    end
                    if (r_idx == IDX_LAST) begin
                        w_sent_nxt  = 1'b1;
                        w_cnt_nxt   = r_cnt + 8'd1;
                        w_gap_nxt   = '0;
                        w_state_nxt = S_GAP;
                    end else begin
                        w_idx_nxt   = r_idx + IDX_W'(1);
                        w_state_nxt = S_LOAD;
                    end
                end else if (r_tmo == TMO_LAST) begin
                    w_err_nxt   = 1'b1;
                    w_gap_nxt   = '0;
                    w_state_nxt = S_GAP;
                end else begin
                    w_tmo_nxt = r_tmo + TMO_W'(1);
                end
            end
            S_GAP: begin
                if (r_gap == GAP_LAST) begin
                    w_gap_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_gap_nxt = r_gap + GAP_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt == S_SNAP) || (w_state_nxt == S_LOAD) ||
                     (w_state_nxt == S_WAIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_tmo   <= '0;
            r_gap   <= '0;
            r_csum  <= '0;
            r_data  <= '0;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_sent  <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_tmo   <= w_tmo_nxt;
            r_gap   <= w_gap_nxt;
            r_csum  <= w_csum_nxt;
            r_data  <= w_data_nxt;
            r_start <= w_start_nxt;
            r_busy  <= w_busy_nxt;
            r_sent  <= w_sent_nxt;
            r_err   <= w_err_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Shadow copy keeps a frame coherent while game logic keeps updating.
    always_ff @(posedge clk) begin
        if (w_snap) begin
            for (int k = 0; k < N_FIELDS; k++) begin
                r_shadow[k] <= fields_in[k*WORD_W +: WORD_W];
            end
        end
    end

    assign tx_if.data_out = r_data;
    assign tx_if.tx_start = r_start;
    assign busy           = r_busy;
    assign frame_sent     = r_sent;
    assign tx_err         = r_err;
    assign frame_cnt      = r_cnt;
endmodule

// File: tb/tb_uart_frame_mux.sv
// Directed bench for uart_frame_mux with a delayed-response UART word model.
module tb_uart_frame_mux;
    localparam int unsigned WW  = 16;
    localparam int unsigned NF  = 3;
    localparam int unsigned FG  = 8;
    localparam int unsigned TMO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [NF*WW-1:0] fields;
    logic          busy, frame_sent, tx_err;
    logic [7:0]    frame_cnt;

    uart_frame_mux_if #(.WORD_W(WW)) uif ();

    uart_frame_mux #(
        .WORD_W(WW), .N_FIELDS(NF), .SYNC_WORD(16'hA55A),
        .FRAME_GAP(FG), .TX_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .fields_in(fields),
        .tx_if(uif), .busy(busy), .frame_sent(frame_sent),
        .tx_err(tx_err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // UART model: tx_done resp_delay cycles after tx_start, optionally withholding one word.
    int   resp_delay  = 10;
    int   withhold_at = -1;
    int   m_starts    = 0;
    int   m_cnt       = 0;
    logic m_done      = 1'b0;
    logic man_done    = 1'b0;
    assign uif.tx_done = m_done | man_done;

    always @(posedge clk) begin
        m_done <= 1'b0;
        if (rst) begin
            m_cnt <= 0;
        end else if (uif.tx_start) begin
            m_starts <= m_starts + 1;
            if (m_starts + 1 != withhold_at) begin
                m_cnt <= resp_delay - 1;
                if (resp_delay == 1) m_done <= 1'b1;
            end
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) m_done <= 1'b1;
        end
    end

    logic [WW-1:0] q[$];
    int sc[$];
    int n_sent = 0, n_err = 0, err_cyc = 0;
    always @(negedge clk) begin
        if (uif.tx_start) begin
            q.push_back(uif.data_out);
            sc.push_back(cyc);
        end
        if (frame_sent) n_sent <= n_sent + 1;
        if (tx_err) begin
            n_err   <= n_err + 1;
            err_cyc <= cyc;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_end(input int budget, output bit to);
        int s0 = n_sent;
        int e0 = n_err;
        to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (n_sent != s0 || n_err != e0) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_busy(input int budget, output bit to);
        to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (busy) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic park();
        enable = 1'b0;
        repeat (FG + 6) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0;
        fields = {16'h0003, 16'h0002, 16'h0001};
        repeat (3) tick();
        n_tests++;
        if ({uif.data_out, uif.tx_start, busy, frame_sent, tx_err, frame_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got data=%h start=%b busy=%b sent=%b err=%b cnt=%0d, want all 0",
                     uif.data_out, uif.tx_start, busy, frame_sent, tx_err, frame_cnt);
        end
        rst = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (uif.tx_start !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_disabled: start=%b busy=%b, want 0 0", uif.tx_start, busy);
        end
    endtask

    task automatic test_basic();
        logic [WW-1:0] exp_w [5];
        bit to;
        int s0 = n_sent;
        exp_w = '{16'hA55A, 16'h0001, 16'h0002, 16'h0003, 16'h0000};
        q.delete(); sc.delete();
        enable = 1'b1;
        wait_end(400, to);
        enable = 1'b0;
        n_tests++;
        if (to || q.size() != 5) begin
            n_fail++;
            $display("FAIL basic_words: timeout=%0d got %0d words, want 5", to, q.size());
        end
        for (int i = 0; i < 5; i++) begin
            if (i < q.size()) begin
                n_tests++;
                if (q[i] !== exp_w[i]) begin
                    n_fail++;
                    $display("FAIL basic_word%0d: got %h want %h", i, q[i], exp_w[i]);
                end
            end
        end
        n_tests++;
        if (n_sent != s0 + 1 || frame_cnt !== 8'd1 || n_err != 0) begin
            n_fail++;
            $display("FAIL basic_sent: sent=%0d cnt=%0d err=%0d, want 1 1 0", n_sent - s0, frame_cnt, n_err);
        end
        park();
    endtask

    task automatic test_snapshot();
        bit to;
        q.delete(); sc.delete();
        enable = 1'b1;
        wait_busy(50, to);
        tick();
        fields[15:0] = 16'h00FF;
        wait_end(400, to);
        n_tests++;
        if (to || q.size() != 5 || q[1] !== 16'h0001 || q[4] !== 16'h0000) begin
            n_fail++;
            $display("FAIL snap_first: timeout=%0d n=%0d f0=%h cs=%h, want 5 0001 0000",
                     to, q.size(), q.size() > 1 ? q[1] : 16'hxxxx, q.size() > 4 ? q[4] : 16'hxxxx);
        end
        q.delete(); sc.delete();
        wait_end(400, to);
        enable = 1'b0;
        n_tests++;
        if (to || q.size() != 5 || q[1] !== 16'h00FF || q[4] !== 16'h00FE || frame_cnt !== 8'd3) begin
            n_fail++;
            $display("FAIL snap_second: timeout=%0d n=%0d f0=%h cs=%h cnt=%0d, want 5 00ff 00fe 3",
                     to, q.size(), q.size() > 1 ? q[1] : 16'hxxxx, q.size() > 4 ? q[4] : 16'hxxxx, frame_cnt);
        end
        park();
        fields = {16'h0003, 16'h0002, 16'h0001};
    endtask

    task automatic test_timeout();
        bit to;
        int s0 = n_sent;
        int e0 = n_err;
        q.delete(); sc.delete();
        withhold_at = m_starts + 3;
        enable = 1'b1;
        wait_end(400, to);
        n_tests++;
        if (to || n_err != e0 + 1 || n_sent != s0 || frame_cnt !== 8'd3) begin
            n_fail++;
            $display("FAIL tmo_abort: timeout=%0d err=%0d sent=%0d cnt=%0d, want 1 0 3",
                     to, n_err - e0, n_sent - s0, frame_cnt);
        end
        n_tests++;
        if (sc.size() < 3 || err_cyc - sc[2] != 15) begin
            n_fail++;
            $display("FAIL tmo_latency: got %0d cycles (starts=%0d), want 15",
                     sc.size() >= 3 ? err_cyc - sc[2] : -1, sc.size());
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_busy_gap: got %b want 0", busy);
        end
        withhold_at = -1;
        q.delete(); sc.delete();
        wait_end(400, to);
        enable = 1'b0;
        n_tests++;
        if (to || n_sent != s0 + 1 || q.size() != 5 || q[4] !== 16'h0000 || frame_cnt !== 8'd4) begin
            n_fail++;
            $display("FAIL tmo_recover: timeout=%0d sent=%0d n=%0d cnt=%0d, want 1 5 4",
                     to, n_sent - s0, q.size(), frame_cnt);
        end
        park();
    endtask

    task automatic test_handshake();
        bit to;
        int s0 = n_sent;
        int e0 = n_err;
        q.delete(); sc.delete();
        enable = 1'b1;
        to = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (uif.tx_start) begin
                to = 1'b0;
                break;
            end
        end
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        wait_end(400, to);
        enable = 1'b0;
        n_tests++;
        if (to || sc.size() < 2 || sc[1] - sc[0] != 12 || n_sent != s0 + 1) begin
            n_fail++;
            $display("FAIL hs_same_cycle: timeout=%0d gap=%0d sent=%0d, want 12 1",
                     to, sc.size() >= 2 ? sc[1] - sc[0] : -1, n_sent - s0);
        end
        park();

        resp_delay = 14;
        q.delete(); sc.delete();
        enable = 1'b1;
        wait_end(400, to);
        enable = 1'b0;
        n_tests++;
        if (to || n_err != e0 || n_sent != s0 + 2 || sc.size() < 2 || sc[1] - sc[0] != 16) begin
            n_fail++;
            $display("FAIL hs_last_count: timeout=%0d err=%0d sent=%0d gap=%0d, want 0 2 16",
                     to, n_err - e0, n_sent - s0, sc.size() >= 2 ? sc[1] - sc[0] : -1);
        end
        park();

        resp_delay = 15;
        q.delete(); sc.delete();
        enable = 1'b1;
        wait_end(400, to);
        enable = 1'b0;
        n_tests++;
        if (to || n_err != e0 + 1 || q.size() != 1 || frame_cnt !== 8'd6) begin
            n_fail++;
            $display("FAIL hs_too_late: timeout=%0d err=%0d words=%0d cnt=%0d, want 1 1 6",
                     to, n_err - e0, q.size(), frame_cnt);
        end
        park();
        resp_delay = 10;
    endtask

    task automatic test_reset_mid();
        bit to;
        q.delete(); sc.delete();
        enable = 1'b1;
        for (int i = 0; i < 200 && q.size() < 2; i++) tick();
        repeat (3) tick();
        rst = 1'b1;
        tick();
        n_tests++;
        if ({uif.data_out, uif.tx_start, busy, frame_sent, tx_err, frame_cnt} !== '0 ||
            dut.r_state !== 3'd0) begin
            n_fail++;
            $display("FAIL rst_mid: data=%h start=%b busy=%b sent=%b err=%b cnt=%0d state=%0d, want all 0",
                     uif.data_out, uif.tx_start, busy, frame_sent, tx_err, frame_cnt, dut.r_state);
        end
        rst = 1'b0;
        q.delete(); sc.delete();
        wait_end(400, to);
        enable = 1'b0;
        n_tests++;
        if (to || q.size() != 5 || q[0] !== 16'hA55A || q[1] !== 16'h0001 || frame_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL rst_restart: timeout=%0d n=%0d w0=%h cnt=%0d, want 5 a55a 1",
                     to, q.size(), q.size() > 0 ? q[0] : 16'hxxxx, frame_cnt);
        end
        park();
    endtask

    task automatic test_enable();
        bit to;
        int s0 = n_sent;
        q.delete(); sc.delete();
        enable = 1'b1;
        wait_busy(50, to);
        enable = 1'b0;
        wait_end(400, to);
        n_tests++;
        if (to || n_sent != s0 + 1 || q.size() != 5) begin
            n_fail++;
            $display("FAIL en_finish: timeout=%0d sent=%0d n=%0d, want 1 5", to, n_sent - s0, q.size());
        end
        q.delete();
        repeat (60) tick();
        n_tests++;
        if (q.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL en_parked: starts=%0d busy=%b, want 0 0", q.size(), busy);
        end
    endtask

    task automatic test_wrap();
        bit to;
        bit any_to = 1'b0;
        int e0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        e0 = n_err;
        resp_delay = 2;
        enable = 1'b1;
        for (int f = 0; f < 255; f++) begin
            wait_end(200, to);
            any_to |= to;
        end
        n_tests++;
        if (any_to || frame_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL wrap_255: timeout=%0d cnt=%0d, want 255", any_to, frame_cnt);
        end
        wait_end(200, to);
        enable = 1'b0;
        n_tests++;
        if (to || frame_cnt !== 8'd0 || n_err != e0) begin
            n_fail++;
            $display("FAIL wrap_0: timeout=%0d cnt=%0d err=%0d, want 0 0", to, frame_cnt, n_err - e0);
        end
        park();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_snapshot();
        test_timeout();
        test_handshake();
        test_reset_mid();
        test_enable();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
